serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 164 ++++++++++++++++
 tb/tb_serial_subtractor.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial WIDTH-bit subtractor. It computes A - B one bit per clock,
// starting at the LSB. It uses a single full-subtractor cell and a registered
// borrow.
//
// A start/done handshake brackets each operation:
//   - start is accepted only in IDLE.
//   - busy is high for WIDTH cycles while the bits are processed.
//   - done pulses for one cycle when diff/bout become valid.
// diff/bout hold their value until the next accepted start.
//
// Optional build macro SERIAL_SUBTRACTOR_ADD_EN adds a 'mode' input
// (0 = subtract, 1 = add). In add mode, bout reports the carry-out.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   operation request, sampled in IDLE only
//   a      in   [WIDTH] minuend, captured on accepted start
//   b      in   [WIDTH] subtrahend, captured on accepted start
//   mode   in   (SERIAL_SUBTRACTOR_ADD_EN only) 0=sub, 1=add
//   busy   out  high while bits are shifting
//   done   out  one-cycle result-valid pulse
//   diff   out  [WIDTH] result modulo 2^WIDTH
//   bout   out  final borrow (or carry in add mode)
`timescale 1ns/1ps
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_ADD_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
  logic             mode_q, mode_d;
`endif

  // The single arithmetic cell operates on the current LSBs.
  // br_q holds the borrow (or the carry in add mode).
  logic cell_d, cell_br;

  always_comb begin
    cell_d = sa_q[0] ^ sb_q[0] ^ br_q;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    if (mode_q) begin
      cell_br = (sa_q[0] & sb_q[0]) | (br_q & (sa_q[0] ^ sb_q[0]));
    end else begin
      cell_br = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    end
`else
    cell_br = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    mode_d  = mode_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
          mode_d  = mode;
`endif
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        busy = 1'b1;
        sa_d = sa_q >> 1;
        sb_d = sb_q >> 1;
        // Each result bit enters at the MSB.
        // After WIDTH shifts, the LSB has reached bit 0.
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        br_d   = cell_br;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bout_d  = cell_br;
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_ADD_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       mode;
  logic       busy, done, bout;
  logic [7:0] diff;

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry holds the expected {bout, diff} for one issued operation.
  logic [8:0] sb[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    .mode  (mode),
`endif
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic m);
    logic [8:0] r;
    if (m) begin
      r = {1'b0, x} + {1'b0, y};
    end else begin
      r[7:0] = x - y;
      r[8]   = (x < y);
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation and returns just after the start edge.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic im,
                       input bit expect_result);
    a = ia;
    b = ib;
    mode = im;
    start = 1'b1;
    if (expect_result) sb.push_back(model(ia, ib, im));
    step();
    start = 1'b0;
  endtask

  // Waits for done with a bounded number of cycles.
  // lat counts the start edge as cycle 1.
  task automatic wait_done(input int lat0, output int lat, output int busy_n, output bit timeout);
    lat = lat0;
    busy_n = 0;
    timeout = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_n++;
      if (lat >= 40) begin
        timeout = 1'b1;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    mode = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({busy, done, bout, diff} !== 11'h000) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: busy=%b done=%b bout=%b diff=%h, required all zero",
                 i, busy, done, bout, diff);
      end
      step();
    end
  endtask

  task automatic test_basic();
    int lat, bn;
    bit to;
    logic [8:0] exp;
    issue(8'h05, 8'h03, 1'b0, 1'b1);
    wait_done(1, lat, bn, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL basic_timeout: done not seen in %0d cycles", lat);
    end
    n_checks++;
    if (lat !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d required 9", lat);
    end
    n_checks++;
    if (bn !== 8) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d required 8", bn);
    end
    exp = sb.pop_front();
    n_checks++;
    if ({bout, diff} !== exp) begin
      n_fail++;
      $display("FAIL basic_result: got bout=%b diff=%h required bout=%b diff=%h",
               bout, diff, exp[8], exp[7:0]);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {bout, diff} !== exp) begin
      n_fail++;
      $display("FAIL basic_after_done: done=%b busy=%b bout=%b diff=%h required 0 0 %b %h",
               done, busy, bout, diff, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_back_to_back(input logic m);
    logic [7:0] av[3] = '{8'h03, 8'h00, 8'hFF};
    logic [7:0] bv[3] = '{8'h05, 8'h00, 8'h01};
    int lat, bn;
    bit to;
    logic [8:0] exp;
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i], m, 1'b1);
      wait_done(1, lat, bn, to);
      exp = sb.pop_front();
      n_checks++;
      if (to || lat !== 9 || {bout, diff} !== exp) begin
        n_fail++;
        $display("FAIL b2b_%0d mode=%b: lat=%0d bout=%b diff=%h required lat=9 bout=%b diff=%h",
                 i, m, lat, bout, diff, exp[8], exp[7:0]);
      end
      // Step to the first IDLE cycle after DONE; the next start goes here.
      step();
      n_checks++;
      if (done !== 1'b0 || diff !== exp[7:0]) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d: done=%b diff=%h required done=0 diff=%h",
                 i, done, diff, exp[7:0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat, bn, extra;
    bit to;
    logic [8:0] exp;
    issue(8'h80, 8'h01, 1'b0, 1'b1);
    step();
    step();
    // Third SHIFT cycle: this request must be ignored.
    a = 8'h11;
    b = 8'h11;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(4, lat, bn, to);
    exp = sb.pop_front();
    n_checks++;
    if (to || lat !== 9 || {bout, diff} !== exp) begin
      n_fail++;
      $display("FAIL ignore_start: lat=%0d bout=%b diff=%h required lat=9 bout=%b diff=%h",
               lat, bout, diff, exp[8], exp[7:0]);
    end
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL ignore_start_extra_op: %0d busy/done cycles seen, required 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bn, seen;
    bit to;
    logic [8:0] exp;
    issue(8'h10, 8'h20, 1'b0, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({busy, done, bout, diff} !== 11'h000) begin
      n_fail++;
      $display("FAIL abort_state: busy=%b done=%b bout=%b diff=%h required all zero",
               busy, done, bout, diff);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) seen++;
      step();
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: %0d done pulses, required 0", seen);
    end
    issue(8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(1, lat, bn, to);
    exp = sb.pop_front();
    n_checks++;
    if (to || {bout, diff} !== exp) begin
      n_fail++;
      $display("FAIL abort_rerun: bout=%b diff=%h required bout=%b diff=%h",
               bout, diff, exp[8], exp[7:0]);
    end
    step();
  endtask

`ifdef SERIAL_SUBTRACTOR_ADD_EN
  task automatic test_add();
    logic [7:0] av[2] = '{8'hFF, 8'h12};
    logic [7:0] bv[2] = '{8'h01, 8'h34};
    int lat, bn;
    bit to;
    logic [8:0] exp;
    for (int i = 0; i < 2; i++) begin
      issue(av[i], bv[i], 1'b1, 1'b1);
      wait_done(1, lat, bn, to);
      exp = sb.pop_front();
      n_checks++;
      if (to || lat !== 9 || {bout, diff} !== exp) begin
        n_fail++;
        $display("FAIL add_%0d: lat=%0d bout=%b diff=%h required lat=9 bout=%b diff=%h",
                 i, lat, bout, diff, exp[8], exp[7:0]);
      end
      step();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    step();
    test_back_to_back(1'b0);
    step();
    test_start_ignored();
    test_reset_abort();
`ifdef SERIAL_SUBTRACTOR_ADD_EN
    test_add();
    test_back_to_back(1'b0);
`endif
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
